// File: rtl/mem_pkg.sv
// Shared types and default widths for the memory access controller and its arbiter.
package mem_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    typedef enum logic {
        REQ_IF,
        REQ_LS
    } req_id_t;

endpackage

// File: rtl/mem_arb2.sv
// Two-way requester arbiter: fixed load/store priority by default,
// round-robin between fetch and load/store when MEM_ARB_FAIR_EN is defined.
module mem_arb2
    import mem_pkg::*;
(
`ifdef MEM_ARB_FAIR_EN
    input  logic    clk,
    input  logic    reset,
    input  logic    accept,
`endif
    input  logic    if_valid,
    input  logic    ls_valid,
    output logic    grant_valid,
    output req_id_t grant_id
);

    assign grant_valid = if_valid | ls_valid;

`ifdef MEM_ARB_FAIR_EN
    req_id_t last_grant;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= REQ_IF;
        end else if (accept) begin
            last_grant <= grant_id;
        end
    end

    // On contention favour whichever side was not served by the previous handshake.
    always_comb begin
        grant_id = REQ_IF;
        if (if_valid && ls_valid) begin
            grant_id = (last_grant == REQ_IF) ? REQ_LS : REQ_IF;
        end else if (ls_valid) begin
            grant_id = REQ_LS;
        end
    end
`else
    always_comb begin
        grant_id = ls_valid ? REQ_LS : REQ_IF;
    end
`endif

endmodule

// File: rtl/mem_access_ctrl.sv
// Shares one single-port memory between instruction fetch and load/store,
// one access per three cycles. Optional round-robin arbitration: MEM_ARB_FAIR_EN.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_rsp_valid,
    output logic [DATA_W-1:0] if_rsp_data,
    input  logic              ls_req_valid,
    output logic              ls_req_ready,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_rsp_valid,
    output logic [DATA_W-1:0] ls_rsp_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t            state;
    state_t            next_state;
    logic              grant_valid;
    req_id_t           grant_id;
    logic              hs;
    req_id_t           lat_id;
    logic [ADDR_W-1:0] lat_addr;
    logic              lat_we;
    logic [DATA_W-1:0] lat_wdata;

    mem_arb2 u_arb (
`ifdef MEM_ARB_FAIR_EN
        .clk         (clk),
        .reset       (reset),
        .accept      (hs),
`endif
        .if_valid    (if_req_valid),
        .ls_valid    (ls_req_valid),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    assign hs = (state == IDLE) && grant_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (hs) next_state = ACCESS;
            ACCESS:  next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Request fields are frozen at the handshake so later input changes cannot disturb the access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_id      <= REQ_IF;
            lat_addr    <= '0;
            lat_we      <= 1'b0;
            lat_wdata   <= '0;
            if_rsp_data <= '0;
            ls_rsp_data <= '0;
        end else begin
            if (hs) begin
                lat_id    <= grant_id;
                lat_addr  <= (grant_id == REQ_LS) ? ls_addr : if_addr;
                lat_we    <= (grant_id == REQ_LS) ? ls_we : 1'b0;
                lat_wdata <= (grant_id == REQ_LS) ? ls_wdata : '0;
            end
            if (state == ACCESS) begin
                if (lat_id == REQ_LS) begin
                    ls_rsp_data <= lat_we ? '0 : mem_rdata;
                end else begin
                    if_rsp_data <= mem_rdata;
                end
            end
        end
    end

    // Ready is gated by reset so nothing appears granted while the block is held in reset.
    always_comb begin
        if_req_ready = 1'b0;
        ls_req_ready = 1'b0;
        if_rsp_valid = 1'b0;
        ls_rsp_valid = 1'b0;
        mem_addr     = '0;
        mem_we       = 1'b0;
        mem_wdata    = '0;
        case (state)
            IDLE: begin
                if_req_ready = reset && grant_valid && (grant_id == REQ_IF);
                ls_req_ready = reset && grant_valid && (grant_id == REQ_LS);
            end
            ACCESS: begin
                mem_addr  = lat_addr;
                mem_we    = lat_we;
                mem_wdata = lat_wdata;
            end
            RESP: begin
                if_rsp_valid = (lat_id == REQ_IF);
                ls_rsp_valid = (lat_id == REQ_LS);
            end
            default: ;
        endcase
    end

endmodule
